// File: rtl/sar_comp_ctrl.sv
// Successive-approximation controller: binary-searches the hidden b operand of an
// external combinational comparator, MSB first, one trial bit per clock.
module sar_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_W = ONE_W << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] acc_r, acc_s, acc_upd_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             exact_r, exact_s;
  logic             err_r, err_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] trial_bit_s;

  // State and datapath registers; every output is a flop so a is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= {WIDTH{1'b0}};
      idx_r    <= {IW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      exact_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      idx_r    <= idx_s;
      a_r      <= a_s;
      result_r <= result_s;
      exact_r  <= exact_s;
      err_r    <= err_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  // Next-state, next-trial and result logic; busy/done/a are computed for the coming state.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    idx_s       = idx_r;
    a_s         = {WIDTH{1'b0}};
    result_s    = result_r;
    exact_s     = exact_r;
    err_s       = err_r;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    trial_bit_s = ONE_W << idx_r;
    acc_upd_s   = l ? (acc_r | trial_bit_s) : acc_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SEARCH;
          acc_s   = {WIDTH{1'b0}};
          idx_s   = IW'(WIDTH - 1);
          exact_s = 1'b0;
          err_s   = 1'b0;
          a_s     = MSB_W;
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SEARCH: begin
        if (!$onehot({l, e, g})) begin
          // Contradictory comparator response: abort without a usable result.
          state_s  = DONE;
          err_s    = 1'b1;
          exact_s  = 1'b0;
          result_s = {WIDTH{1'b0}};
          done_s   = 1'b1;
        end else if (e) begin
          state_s  = DONE;
          result_s = a_r;
          exact_s  = 1'b1;
          done_s   = 1'b1;
        end else if (idx_r == {IW{1'b0}}) begin
          state_s  = DONE;
          acc_s    = acc_upd_s;
          result_s = acc_upd_s;
          exact_s  = 1'b0;
          done_s   = 1'b1;
        end else begin
          acc_s  = acc_upd_s;
          idx_s  = idx_r - {{(IW-1){1'b0}}, 1'b1};
          a_s    = acc_upd_s | (trial_bit_s >> 1);
          busy_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign a      = a_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign exact  = exact_r;
  assign err    = err_r;

endmodule

// File: tb/tb_sar_comp_ctrl.sv
// Bench for sar_comp_ctrl: models the comparator on a hidden b and predicts the
// trial sequence, latency and result from the binary-search rules directly.
module tb_sar_comp_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, result;
  logic         l, e, g, busy, done, exact, err;
  logic [W-1:0] hidden_b;
  logic         force_bad;
  logic [W-1:0] a_seq[$];
  int           vectors = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  assign l = !force_bad && (a < hidden_b);
  assign e = !force_bad && (a == hidden_b);
  assign g = !force_bad && (a > hidden_b);

  sar_comp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .l(l), .e(e), .g(g),
    .busy(busy), .done(done), .result(result), .exact(exact), .err(err)
  );

  // Expected trial when bit i is being tested: b's bits above i, plus bit i.
  function automatic logic [W-1:0] exp_trial(input logic [W-1:0] b, input int i);
    logic [W-1:0] hi_mask;
    logic [W-1:0] one;
    one = 1;
    hi_mask = (i >= W - 1) ? '0 : ({W{1'b1}} << (i + 1));
    return (b & hi_mask) | (one << i);
  endfunction

  // Evaluations needed: e fires at b's lowest set bit; b = 0 never matches.
  function automatic int exp_evals(input logic [W-1:0] b);
    int tz;
    if (b == '0) return W;
    tz = 0;
    while (b[tz] == 1'b0) tz++;
    return W - tz;
  endfunction

  // Runs one search from IDLE, recording trials; cycles = cycle count at which done was seen.
  task automatic drive_search(input logic [W-1:0] bv, input int bad_eval,
                              input int restart_at, output int cycles, output int evals);
    @(posedge clk); #1;
    hidden_b = bv;
    a_seq.delete();
    evals = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (!done && cycles <= W + 3) begin
      if (busy) begin
        evals++;
        a_seq.push_back(a);
      end
      force_bad = busy && (evals == bad_eval);
      start = (cycles == restart_at);
      @(posedge clk); #1;
      force_bad = 1'b0;
      start = 1'b0;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (a !== '0) begin miscompares++; $display("FAIL reset_a got %h want 00", a); end
    vectors++; if ({result, exact, err} !== '0) begin miscompares++;
      $display("FAIL reset_result got %h/%b/%b want 00/0/0", result, exact, err); end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_typical();
    int cyc, ev;
    logic [W-1:0] want[7];
    want = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
    drive_search(8'h5A, 0, 0, cyc, ev);
    vectors++; if (cyc !== 8) begin miscompares++; $display("FAIL 5a_latency got %0d want 8", cyc); end
    vectors++; if (ev !== 7) begin miscompares++; $display("FAIL 5a_evals got %0d want 7", ev); end
    for (int i = 0; i < 7 && i < a_seq.size(); i++) begin
      vectors++; if (a_seq[i] !== want[i]) begin miscompares++;
        $display("FAIL 5a_trial%0d got %h want %h", i, a_seq[i], want[i]); end
    end
    vectors++; if ({result, exact, err} !== {8'h5A, 1'b1, 1'b0}) begin miscompares++;
      $display("FAIL 5a_result got %h/%b/%b want 5a/1/0", result, exact, err); end
  endtask

  task automatic test_exact_msb();
    int cyc, ev;
    drive_search(8'h80, 0, 0, cyc, ev);
    vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL 80_latency got %0d want 2", cyc); end
    vectors++; if (ev !== 1) begin miscompares++; $display("FAIL 80_busy_cycles got %0d want 1", ev); end
    vectors++; if ({result, exact} !== {8'h80, 1'b1}) begin miscompares++;
      $display("FAIL 80_result got %h/%b want 80/1", result, exact); end
    @(posedge clk); #1;
    vectors++; if ({done, busy, a} !== {2'b00, 8'h00}) begin miscompares++;
      $display("FAIL 80_after_done got done=%b busy=%b a=%h want 0/0/00", done, busy, a); end
    vectors++; if ({result, exact} !== {8'h80, 1'b1}) begin miscompares++;
      $display("FAIL 80_hold got %h/%b want 80/1", result, exact); end
  endtask

  task automatic test_zero();
    int cyc, ev;
    drive_search(8'h00, 0, 0, cyc, ev);
    vectors++; if (cyc !== 9) begin miscompares++; $display("FAIL 00_latency got %0d want 9", cyc); end
    vectors++; if (ev !== 8) begin miscompares++; $display("FAIL 00_evals got %0d want 8", ev); end
    vectors++; if ({result, exact, err} !== {8'h00, 1'b0, 1'b0}) begin miscompares++;
      $display("FAIL 00_result got %h/%b/%b want 00/0/0", result, exact, err); end
  endtask

  task automatic test_illegal();
    int cyc, ev;
    drive_search(8'h3C, 3, 0, cyc, ev);
    vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL err_latency got %0d want 4", cyc); end
    vectors++; if ({result, exact, err} !== {8'h00, 1'b0, 1'b1}) begin miscompares++;
      $display("FAIL err_result got %h/%b/%b want 00/0/1", result, exact, err); end
  endtask

  task automatic test_mid_reset();
    int cyc, ev, done_seen;
    @(posedge clk); #1;
    hidden_b = 8'h3C;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if ({a, result, busy, done, exact, err} !== '0) begin miscompares++;
      $display("FAIL rst_mid got a=%h res=%h busy=%b done=%b exact=%b err=%b want all 0",
               a, result, busy, done, exact, err); end
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL rst_no_done got %0d want 0", done_seen); end
    // rst wins over start on the same edge
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_priority got %b want 0", busy); end
    drive_search(8'hFF, 0, 0, cyc, ev);
    vectors++; if (cyc !== 9) begin miscompares++; $display("FAIL ff_latency got %0d want 9", cyc); end
    vectors++; if ({result, exact} !== {8'hFF, 1'b1}) begin miscompares++;
      $display("FAIL ff_result got %h/%b want ff/1", result, exact); end
  endtask

  task automatic test_back_to_back();
    int cyc, ev, dones;
    drive_search(8'h11, 0, 2, cyc, ev);
    vectors++; if (cyc !== 1 + exp_evals(8'h11)) begin miscompares++;
      $display("FAIL 11_latency got %0d want %0d", cyc, 1 + exp_evals(8'h11)); end
    vectors++; if ({result, exact} !== {8'h11, 1'b1}) begin miscompares++;
      $display("FAIL 11_result got %h/%b want 11/1", result, exact); end
    // start during DONE must not launch a search
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) dones++;
      @(posedge clk); #1;
    end
    vectors++; if (dones !== 0) begin miscompares++; $display("FAIL done_start_ignored got %0d want 0", dones); end
  endtask

  task automatic test_random();
    int cyc, ev, k;
    logic [W-1:0] b;
    for (int n = 0; n < 24; n++) begin
      b = W'($urandom_range(0, 255));
      k = exp_evals(b);
      drive_search(b, 0, 0, cyc, ev);
      vectors++; if (cyc !== k + 1) begin miscompares++;
        $display("FAIL rnd_latency b=%h got %0d want %0d", b, cyc, k + 1); end
      vectors++; if ({result, exact, err} !== {b, (b != '0), 1'b0}) begin miscompares++;
        $display("FAIL rnd_result b=%h got %h/%b/%b want %h/%b/0", b, result, exact, err, b, (b != '0)); end
      vectors++; if (a_seq.size() !== k) begin miscompares++;
        $display("FAIL rnd_trials b=%h got %0d want %0d", b, a_seq.size(), k); end
      for (int j = 0; j < k && j < a_seq.size(); j++) begin
        vectors++; if (a_seq[j] !== exp_trial(b, W - 1 - j)) begin miscompares++;
          $display("FAIL rnd_trial b=%h j=%0d got %h want %h", b, j, a_seq[j], exp_trial(b, W - 1 - j)); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; force_bad = 1'b0; hidden_b = '0;
    test_reset();
    test_typical();
    test_exact_msb();
    test_zero();
    test_illegal();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
